rob_commit_unit: RTL and testbench

ROB_COMMIT_UNIT -- requirements
Module: rob_commit_unit

---
 rtl/rob_commit_unit_if.sv | 50 +++++
 rtl/rob_commit_unit.sv | 105 ++++++++++
 tb/tb_rob_commit_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_unit_if.sv
// Dispatch, broadcast, lookup and retirement signals of the reorder buffer.
// The slave side is the ROB itself; the master side is the surrounding pipeline.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 3
`endif

interface rob_commit_unit_if #(
    parameter int ROB_TAG_LEN = `ROB_TAG_LEN
);
    logic                   dispatch_en;
    logic [4:0]             dispatch_rd;
    logic [ROB_TAG_LEN-1:0] rob_entry_in;
    logic                   rob_full;

    logic                   cdb_valid;
    logic [ROB_TAG_LEN-1:0] cdb_tag;
    logic [31:0]            cdb_value;

    logic                   valid_wb;
    logic [4:0]             rd_wb;
    logic [ROB_TAG_LEN-1:0] rob_entry_wb;

    logic                   commit;
    logic [4:0]             rd_commit;
    logic [ROB_TAG_LEN-1:0] rob_entry_commit;
    logic [31:0]            commit_value;

    logic [ROB_TAG_LEN-1:0] rs1_tag;
    logic [ROB_TAG_LEN-1:0] rs2_tag;
    logic [31:0]            rs1_value;
    logic [31:0]            rs2_value;

    logic                   flush;

    modport master (
        output dispatch_en, dispatch_rd, cdb_valid, cdb_tag, cdb_value,
        output rs1_tag, rs2_tag, flush,
        input  rob_entry_in, rob_full, valid_wb, rd_wb, rob_entry_wb,
        input  commit, rd_commit, rob_entry_commit, commit_value,
        input  rs1_value, rs2_value
    );

    modport slave (
        input  dispatch_en, dispatch_rd, cdb_valid, cdb_tag, cdb_value,
        input  rs1_tag, rs2_tag, flush,
        output rob_entry_in, rob_full, valid_wb, rd_wb, rob_entry_wb,
        output commit, rd_commit, rob_entry_commit, commit_value,
        output rs1_value, rs2_value
    );
endinterface

// File: rtl/rob_commit_unit.sv
// Reorder buffer: in-order allocate, out-of-order completion, in-order retire.
// Tag 0 means "no ROB mapping", so the pointers cycle through 1..N-1 only.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 3
`endif

module rob_commit_unit #(
    parameter int ROB_TAG_LEN = `ROB_TAG_LEN
) (
    input logic               clock,
    input logic               reset,
    rob_commit_unit_if.slave  rob
);
    localparam int TW = ROB_TAG_LEN;
    localparam int N  = 1 << TW;

    logic [N-1:0]  valid_q;
    logic [N-1:0]  done_q;
    logic [4:0]    rd_q    [N];
    logic [31:0]   value_q [N];
    logic [TW-1:0] head_q;
    logic [TW-1:0] tail_q;
    logic [TW-1:0] count_q;

    logic full;
    logic cdb_ok;
    logic commit_ok;
    logic disp_ok;

    function automatic logic [TW-1:0] bump(input logic [TW-1:0] p);
        return (p == TW'(N - 1)) ? TW'(1) : p + TW'(1);
    endfunction

    function automatic logic [31:0] lookup(input logic [TW-1:0] tag);
        if (tag == '0)
            return 32'd0;
        if (rob.cdb_valid && rob.cdb_tag == tag)
            return rob.cdb_value;
        return value_q[tag];
    endfunction

    assign full      = (count_q == TW'(N - 1));
    assign cdb_ok    = rob.cdb_valid && (rob.cdb_tag != '0)
                       && valid_q[rob.cdb_tag] && !done_q[rob.cdb_tag];
    assign commit_ok = (count_q != '0) && valid_q[head_q] && done_q[head_q];
    assign disp_ok   = rob.dispatch_en && !full && !rob.flush;

    assign rob.rob_entry_in = tail_q;
    assign rob.rob_full     = full;

    assign rob.valid_wb     = cdb_ok;
    assign rob.rob_entry_wb = cdb_ok ? rob.cdb_tag : '0;
    assign rob.rd_wb        = cdb_ok ? rd_q[rob.cdb_tag] : 5'd0;

    assign rob.commit           = commit_ok;
    assign rob.rob_entry_commit = commit_ok ? head_q : '0;
    assign rob.rd_commit        = commit_ok ? rd_q[head_q] : 5'd0;
    assign rob.commit_value     = commit_ok ? value_q[head_q] : 32'd0;

    assign rob.rs1_value = lookup(rob.rs1_tag);
    assign rob.rs2_value = lookup(rob.rs2_tag);

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            done_q  <= '0;
            for (int i = 0; i < N; i++) begin
                rd_q[i]    <= 5'd0;
                value_q[i] <= 32'd0;
            end
            head_q  <= TW'(1);
            tail_q  <= TW'(1);
            count_q <= '0;
        end else if (rob.flush) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= TW'(1);
            tail_q  <= TW'(1);
            count_q <= '0;
        end else begin
            // Head and tail never collide: a full ROB blocks dispatch,
            // an empty one cannot commit.
            if (commit_ok) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= bump(head_q);
            end
            if (cdb_ok) begin
                done_q[rob.cdb_tag]  <= 1'b1;
                value_q[rob.cdb_tag] <= rob.cdb_value;
            end
            if (disp_ok) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                rd_q[tail_q]    <= rob.dispatch_rd;
                tail_q          <= bump(tail_q);
            end
            unique case ({disp_ok, commit_ok})
                2'b10:   count_q <= count_q + TW'(1);
                2'b01:   count_q <= count_q - TW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit with an 8-tag (7-entry) ROB.
// Expected values are hand-derived from the allocation/retire rules.
module tb_rob_commit_unit;
    localparam int L = 3;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    rob_commit_unit_if #(.ROB_TAG_LEN(L)) rob ();

    rob_commit_unit #(.ROB_TAG_LEN(L)) dut (
        .clock (clock),
        .reset (reset),
        .rob   (rob.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rob.dispatch_en = 1'b0;
        rob.dispatch_rd = 5'd0;
        rob.cdb_valid   = 1'b0;
        rob.cdb_tag     = '0;
        rob.cdb_value   = 32'd0;
        rob.flush       = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic dispatch(input logic [4:0] rd);
        rob.dispatch_en = 1'b1;
        rob.dispatch_rd = rd;
        tick();
        rob.dispatch_en = 1'b0;
    endtask

    task automatic bcast(input logic [L-1:0] tag, input logic [31:0] v);
        rob.cdb_valid = 1'b1;
        rob.cdb_tag   = tag;
        rob.cdb_value = v;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_entry_in"}, 32'(rob.rob_entry_in), 32'd1);
        chk({pfx, "_full"}, 32'(rob.rob_full), 32'd0);
        chk({pfx, "_valid_wb"}, 32'(rob.valid_wb), 32'd0);
        chk({pfx, "_commit"}, 32'(rob.commit), 32'd0);
        chk({pfx, "_commit_value"}, rob.commit_value, 32'd0);
        chk({pfx, "_rd_commit"}, 32'(rob.rd_commit), 32'd0);
        chk({pfx, "_rs1_value"}, rob.rs1_value, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rob.rs1_tag = '0;
        rob.rs2_tag = '0;
        do_reset();
        chk_reset_vals("rst");

        // Single dispatch, broadcast, retire.
        rob.dispatch_en = 1'b1;
        rob.dispatch_rd = 5'd5;
        #1;
        chk("disp_tag", 32'(rob.rob_entry_in), 32'd1);
        tick();
        rob.dispatch_en = 1'b0;
        #1;
        chk("disp_next", 32'(rob.rob_entry_in), 32'd2);
        bcast(3'd1, 32'hAB);
        #1;
        chk("wb_valid", 32'(rob.valid_wb), 32'd1);
        chk("wb_rd", 32'(rob.rd_wb), 32'd5);
        chk("wb_entry", 32'(rob.rob_entry_wb), 32'd1);
        chk("no_early_commit", 32'(rob.commit), 32'd0);
        tick();
        idle();
        #1;
        chk("commit", 32'(rob.commit), 32'd1);
        chk("rd_commit", 32'(rob.rd_commit), 32'd5);
        chk("entry_commit", 32'(rob.rob_entry_commit), 32'd1);
        chk("commit_value", rob.commit_value, 32'hAB);
        tick();
        chk("commit_once", 32'(rob.commit), 32'd0);

        // Fill, overflow, wrap skipping tag 0, blocked dispatch on commit.
        do_reset();
        for (int i = 1; i <= 7; i++)
            dispatch(5'(i));
        #1;
        chk("full", 32'(rob.rob_full), 32'd1);
        chk("full_tail_wrap", 32'(rob.rob_entry_in), 32'd1);
        dispatch(5'd8);
        #1;
        chk("ovf_tail", 32'(rob.rob_entry_in), 32'd1);
        chk("ovf_full", 32'(rob.rob_full), 32'd1);
        bcast(3'd1, 32'h10);
        #1;
        chk("ovf_rd_kept", 32'(rob.rd_wb), 32'd1);
        tick();
        idle();
        rob.dispatch_en = 1'b1;
        rob.dispatch_rd = 5'd9;
        #1;
        chk("full_commit", 32'(rob.commit), 32'd1);
        chk("full_commit_val", rob.commit_value, 32'h10);
        tick();
        rob.dispatch_en = 1'b0;
        #1;
        chk("after_commit_full", 32'(rob.rob_full), 32'd0);
        chk("blocked_tail", 32'(rob.rob_entry_in), 32'd1);
        chk("head2_not_done", 32'(rob.commit), 32'd0);
        dispatch(5'd10);
        #1;
        chk("wrap_next", 32'(rob.rob_entry_in), 32'd2);
        chk("refull", 32'(rob.rob_full), 32'd1);
        bcast(3'd1, 32'h77);
        #1;
        chk("wrap_rd", 32'(rob.rd_wb), 32'd10);
        idle();

        // Out-of-order completion, in-order retire, operand forwarding.
        do_reset();
        dispatch(5'd1);
        dispatch(5'd2);
        dispatch(5'd3);
        bcast(3'd3, 32'h33);
        #1;
        chk("ooo_wb3", 32'(rob.valid_wb), 32'd1);
        tick();
        bcast(3'd2, 32'h55);
        rob.rs1_tag = 3'd2;
        rob.rs2_tag = 3'd3;
        #1;
        chk("fwd_rs1", rob.rs1_value, 32'h55);
        chk("stored_rs2", rob.rs2_value, 32'h33);
        chk("ooo_wait2", 32'(rob.commit), 32'd0);
        tick();
        bcast(3'd3, 32'h99);
        rob.rs1_tag = '0;
        #1;
        chk("done_ignored", 32'(rob.valid_wb), 32'd0);
        chk("tag0_rs1", rob.rs1_value, 32'd0);
        chk("ooo_wait1", 32'(rob.commit), 32'd0);
        bcast(3'd0, 32'h12);
        #1;
        chk("tag0_bcast", 32'(rob.valid_wb), 32'd0);
        bcast(3'd1, 32'h11);
        #1;
        chk("ooo_wait0", 32'(rob.commit), 32'd0);
        tick();
        idle();
        #1;
        chk("ooo_c1", 32'(rob.rob_entry_commit), 32'd1);
        chk("ooo_v1", rob.commit_value, 32'h11);
        tick();
        chk("ooo_c2", 32'(rob.rob_entry_commit), 32'd2);
        chk("ooo_v2", rob.commit_value, 32'h55);
        tick();
        chk("ooo_c3", 32'(rob.rob_entry_commit), 32'd3);
        chk("ooo_v3", rob.commit_value, 32'h33);
        chk("ooo_rd3", 32'(rob.rd_commit), 32'd3);
        tick();
        chk("ooo_empty", 32'(rob.commit), 32'd0);
        rob.rs2_tag = '0;

        // Flush with concurrent dispatch and broadcast.
        do_reset();
        for (int i = 0; i < 4; i++)
            dispatch(5'(i + 4));
        bcast(3'd1, 32'hC1);
        tick();
        idle();
        #1;
        chk("pre_flush_tail", 32'(rob.rob_entry_in), 32'd5);
        rob.flush = 1'b1;
        rob.dispatch_en = 1'b1;
        rob.dispatch_rd = 5'd20;
        bcast(3'd2, 32'hC2);
        #1;
        chk("flush_commit", 32'(rob.commit), 32'd1);
        chk("flush_commit_e", 32'(rob.rob_entry_commit), 32'd1);
        tick();
        idle();
        #1;
        chk("post_flush_tail", 32'(rob.rob_entry_in), 32'd1);
        chk("post_flush_full", 32'(rob.rob_full), 32'd0);
        chk("post_flush_commit", 32'(rob.commit), 32'd0);
        bcast(3'd2, 32'hC3);
        #1;
        chk("post_flush_wb", 32'(rob.valid_wb), 32'd0);
        idle();

        // Reset mid-stream beats dispatch, broadcast and commit.
        dispatch(5'd7);
        dispatch(5'd8);
        bcast(3'd1, 32'hD1);
        tick();
        rob.cdb_valid = 1'b0;
        rob.dispatch_en = 1'b1;
        rob.dispatch_rd = 5'd9;
        bcast(3'd2, 32'hD2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        rob.rs1_tag = 3'd1;
        #1;
        chk_reset_vals("mid_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
